// File: rtl/multicycle_shifter_pkg.sv
// Shared shift-unit definitions: direction codes, FSM encoding and level walking helper.
package multicycle_shifter_pkg;

    localparam logic SHIFT_SLL = 1'b0;
    localparam logic SHIFT_SRA = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Level k shifts by 16 >> k; level 4 is the 1-bit level.
    localparam logic [2:0] LevelFirst = 3'd0;
    localparam logic [2:0] LevelLast  = 3'd4;
    localparam logic [2:0] LevelEnd   = 3'd5;

    // Lowest level >= from whose shamt bit (4 - level) is set, or LevelEnd if none remain.
    function automatic logic [2:0] next_set_level(input logic [4:0] shamt,
                                                  input logic [2:0] from);
        logic [2:0] lvl;
        lvl = LevelEnd;
        for (int k = 4; k >= 0; k--) begin
            if (k >= int'(from) && shamt[4 - k]) begin
                lvl = 3'(k);
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/multicycle_shifter_if.sv
// Request/response bundle between the CPU pipeline and the iterative shifter.
interface multicycle_shifter_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic        ctrl_arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        busy;

    modport master (
        output in_valid, data_operandA, ctrl_shiftamt, ctrl_arith, out_ready,
        input  in_ready, out_valid, data_result, busy
    );

    modport slave (
        input  in_valid, data_operandA, ctrl_shiftamt, ctrl_arith, out_ready,
        output in_ready, out_valid, data_result, busy
    );

endinterface

// File: rtl/multicycle_shifter_shift_level.sv
// One level of the shifter: sll or sra by 2^(4-level), bypassed when not enabled.
module shift_level
    import multicycle_shifter_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  level,
    input  logic        dir,
    input  logic        enable,
    output logic [31:0] data_out
);

    logic        sign;
    logic [31:0] sll_val;
    logic [31:0] sra_val;

    assign sign = data_in[31];

    always_comb begin
        sll_val = data_in;
        sra_val = data_in;
        case (level)
            3'd0: begin
                sll_val = {data_in[15:0], 16'h0};
                sra_val = {{16{sign}}, data_in[31:16]};
            end
            3'd1: begin
                sll_val = {data_in[23:0], 8'h0};
                sra_val = {{8{sign}}, data_in[31:8]};
            end
            3'd2: begin
                sll_val = {data_in[27:0], 4'h0};
                sra_val = {{4{sign}}, data_in[31:4]};
            end
            3'd3: begin
                sll_val = {data_in[29:0], 2'b0};
                sra_val = {{2{sign}}, data_in[31:2]};
            end
            3'd4: begin
                sll_val = {data_in[30:0], 1'b0};
                sra_val = {sign, data_in[31:1]};
            end
            default: ;
        endcase
    end

    assign data_out = !enable             ? data_in :
                      (dir == SHIFT_SRA)  ? sra_val : sll_val;

endmodule

// File: rtl/multicycle_shifter.sv
// Iterative shifter: one barrel level per clock, result held until the consumer takes it.
module multicycle_shifter
    import multicycle_shifter_pkg::*;
#(
    parameter bit          SKIP_ZERO_STAGES = 1'b0,
    parameter int unsigned DATA_WIDTH       = 32
) (
    input logic                 clock,
    input logic                 reset,
    multicycle_shifter_if.slave sh
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [4:0]              shamt_q, shamt_d;
    logic                    dir_q, dir_d;
    logic [2:0]              level_q, level_d;
    logic [2:0]              next_level;
    logic [4:0]              bit_by_level;
    logic                    level_en;
    logic [DATA_WIDTH-1:0]   shifted;

    // bit_by_level[k] is the shamt bit that controls level k.
    assign bit_by_level = {shamt_q[0], shamt_q[1], shamt_q[2], shamt_q[3], shamt_q[4]};
    assign level_en     = bit_by_level[level_q];
    assign next_level   = next_set_level(shamt_q, level_q + 3'd1);

    shift_level u_shift_level (
        .data_in  (data_q),
        .level    (level_q),
        .dir      (dir_q),
        .enable   (level_en),
        .data_out (shifted)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        dir_d   = dir_q;
        level_d = level_q;
        unique case (state_q)
            StIdle: begin
                if (sh.in_valid) begin
                    data_d  = sh.data_operandA;
                    shamt_d = sh.ctrl_shiftamt;
                    dir_d   = sh.ctrl_arith;
                    level_d = LevelFirst;
                    state_d = StShift;
                    if (SKIP_ZERO_STAGES) begin
                        if (sh.ctrl_shiftamt == 5'd0) begin
                            state_d = StDone;
                        end else begin
                            level_d = next_set_level(sh.ctrl_shiftamt, LevelFirst);
                        end
                    end
                end
            end
            StShift: begin
                data_d = shifted;
                if (SKIP_ZERO_STAGES) begin
                    if (next_level == LevelEnd) begin
                        state_d = StDone;
                    end else begin
                        level_d = next_level;
                    end
                end else if (level_q == LevelLast) begin
                    state_d = StDone;
                end else begin
                    level_d = level_q + 3'd1;
                end
            end
            StDone: begin
                if (sh.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            shamt_q <= '0;
            dir_q   <= 1'b0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            dir_q   <= dir_d;
            level_q <= level_d;
        end
    end

    assign sh.in_ready    = (state_q == StIdle);
    assign sh.out_valid   = (state_q == StDone);
    assign sh.busy        = (state_q == StShift) || (state_q == StDone);
    assign sh.data_result = data_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Bench for multicycle_shifter: fixed-latency and skip-zero instances run side by side.
module tb_multicycle_shifter;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] operand;
    logic [4:0]  amt;
    logic        arith;
    logic        out_ready;

    int n_checks;
    int n_fail;

    always #5 clock = ~clock;

    multicycle_shifter_if bus0 ();
    multicycle_shifter_if bus1 ();

    assign bus0.in_valid      = in_valid;
    assign bus0.data_operandA = operand;
    assign bus0.ctrl_shiftamt = amt;
    assign bus0.ctrl_arith    = arith;
    assign bus0.out_ready     = out_ready;
    assign bus1.in_valid      = in_valid;
    assign bus1.data_operandA = operand;
    assign bus1.ctrl_shiftamt = amt;
    assign bus1.ctrl_arith    = arith;
    assign bus1.out_ready     = out_ready;

    multicycle_shifter #(
        .SKIP_ZERO_STAGES (1'b0),
        .DATA_WIDTH       (32)
    ) dut0 (
        .clock (clock),
        .reset (reset),
        .sh    (bus0)
    );

    multicycle_shifter #(
        .SKIP_ZERO_STAGES (1'b1),
        .DATA_WIDTH       (32)
    ) dut1 (
        .clock (clock),
        .reset (reset),
        .sh    (bus1)
    );

    logic [31:0] res_w  [2];
    logic        ov_w   [2];
    logic        ir_w   [2];
    logic        busy_w [2];

    assign res_w[0]  = bus0.data_result;
    assign res_w[1]  = bus1.data_result;
    assign ov_w[0]   = bus0.out_valid;
    assign ov_w[1]   = bus1.out_valid;
    assign ir_w[0]   = bus0.in_ready;
    assign ir_w[1]   = bus1.in_ready;
    assign busy_w[0] = bus0.busy;
    assign busy_w[1] = bus1.busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [4:0] n,
                                              input logic sra);
        logic signed [31:0] s;
        if (sra) begin
            s = $signed(op) >>> n;
            return s;
        end
        return op << n;
    endfunction

    // Transaction-level model: phase 0 idle, 1 shifting (m_left cycles to go), 2 result held.
    int          m_phase [2];
    int          m_left  [2];
    logic [31:0] m_res   [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0;
            m_left[d]  = 0;
            m_res[d]   = '0;
        end
    end

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_phase[d] = 0;
                m_left[d]  = 0;
                m_res[d]   = '0;
            end
            check($sformatf("in_ready[%0d]", d), 32'(ir_w[d]), 32'(m_phase[d] == 0));
            check($sformatf("out_valid[%0d]", d), 32'(ov_w[d]), 32'(m_phase[d] == 2));
            check($sformatf("busy[%0d]", d), 32'(busy_w[d]), 32'(m_phase[d] != 0));
            if (m_phase[d] == 2 || !reset) begin
                check($sformatf("data_result[%0d]", d), res_w[d], m_res[d]);
            end
            if (reset) begin
                case (m_phase[d])
                    0: if (in_valid) begin
                        m_res[d]   = ref_shift(operand, amt, arith);
                        m_left[d]  = (d == 0) ? 5 : $countones(amt);
                        m_phase[d] = (m_left[d] == 0) ? 2 : 1;
                    end
                    1: begin
                        m_left[d]--;
                        if (m_left[d] == 0) m_phase[d] = 2;
                    end
                    default: if (out_ready) m_phase[d] = 0;
                endcase
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!(ir_w[0] && ir_w[1]) && n < 12) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("return_to_idle", 32'(ir_w[0] && ir_w[1]), 32'd1);
    endtask

    // Issues one request to both units from posedge+1 and records each first out_valid edge.
    task automatic run_op(input logic [31:0] op, input logic [4:0] n, input logic sra,
                          input bit pin, input logic [31:0] exp, input int lat0, input int lat1,
                          input bit rnd_ready);
        int          lat [2];
        logic [31:0] got [2];
        int          edges;
        lat[0] = 0;
        lat[1] = 0;
        got[0] = '0;
        got[1] = '0;
        operand  = op;
        amt      = n;
        arith    = sra;
        in_valid = 1'b1;
        edges    = 0;
        while ((lat[0] == 0 || lat[1] == 0) && edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            in_valid = 1'b0;
            operand  = $urandom;
            amt      = 5'($urandom);
            arith    = 1'($urandom);
            for (int d = 0; d < 2; d++) begin
                if (ov_w[d] && lat[d] == 0) begin
                    lat[d] = edges;
                    got[d] = res_w[d];
                end
            end
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
        check("result_timeout", 32'(edges < 40), 32'd1);
        if (pin) begin
            check("latency_fixed", 32'(lat[0]), 32'(lat0));
            check("latency_skip", 32'(lat[1]), 32'(lat1));
            check("result_fixed", got[0], exp);
            check("result_skip", got[1], exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        operand   = '0;
        amt       = '0;
        arith     = 1'b0;
        out_ready = 1'b1;
        #8;
        for (int d = 0; d < 2; d++) begin
            check("reset_in_ready", 32'(ir_w[d]), 32'd1);
            check("reset_out_valid", 32'(ov_w[d]), 32'd0);
            check("reset_result", res_w[d], 32'h0);
        end
        #14;
        reset = 1'b1;
        @(posedge clock);
        #1;

        run_op(32'h0000_0001, 5'd31, 1'b0, 1'b1, 32'h8000_0000, 6, 6, 1'b0);
        wait_idle();
        run_op(32'h8000_0000, 5'd4, 1'b1, 1'b1, 32'hF800_0000, 6, 2, 1'b0);
        wait_idle();
        run_op(32'h7FFF_FFF0, 5'd4, 1'b1, 1'b1, 32'h07FF_FFFF, 6, 2, 1'b0);
        wait_idle();
        run_op(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 6, 1, 1'b0);
        wait_idle();
        run_op(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 6, 1, 1'b0);
        wait_idle();
        run_op(32'h0000_00FF, 5'd8, 1'b0, 1'b1, 32'h0000_FF00, 6, 2, 1'b0);
        wait_idle();
        run_op(32'h0000_0003, 5'b10101, 1'b0, 1'b1, 32'h0060_0000, 6, 4, 1'b0);
        wait_idle();
        run_op(32'h8000_0001, 5'b10101, 1'b1, 1'b1, 32'hFFFF_FC00, 6, 4, 1'b0);
        wait_idle();
        run_op(32'h1234_5679, 5'd31, 1'b0, 1'b1, 32'h8000_0000, 6, 6, 1'b0);
        wait_idle();

        // Backpressure: results must sit untouched while new requests are ignored.
        out_ready = 1'b0;
        run_op(32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h0000_0F00, 6, 2, 1'b0);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            operand  = $urandom;
            @(posedge clock);
            #1;
            for (int d = 0; d < 2; d++) begin
                check("hold_out_valid", 32'(ov_w[d]), 32'd1);
                check("hold_in_ready", 32'(ir_w[d]), 32'd0);
                check("hold_result", res_w[d], 32'h0000_0F00);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("release_in_ready", 32'(ir_w[d]), 32'd1);
            check("release_busy", 32'(busy_w[d]), 32'd0);
        end

        // Asynchronous reset during the second SHIFT cycle.
        operand  = 32'h0000_1234;
        amt      = 5'd31;
        arith    = 1'b0;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("midreset_out_valid", 32'(ov_w[d]), 32'd0);
            check("midreset_in_ready", 32'(ir_w[d]), 32'd1);
            check("midreset_busy", 32'(busy_w[d]), 32'd0);
            check("midreset_result", res_w[d], 32'h0);
        end
        @(posedge clock);
        #3;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            check("no_stale_fixed", 32'(ov_w[0]), 32'd0);
            check("no_stale_skip", 32'(ov_w[1]), 32'd0);
        end

        for (int t = 0; t < 80; t++) begin
            run_op($urandom, 5'($urandom), 1'($urandom), 1'b0, 32'h0, 0, 0, 1'b1);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
